// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Shares the single port of the 8 KB screen RAM between the HDMI video
//   fetcher and the CPU bus. The video fetcher has priority: it gets read
//   data one cycle after presenting a new address. The CPU uses the spare
//   RAM cycles through a 4-phase req/ack handshake. If the CPU waits
//   MAX_WAIT cycles, it is granted the port anyway.
//
// Ports
//   clk_pix      pixel clock, sole clock
//   reset        synchronous, active-high
//   vram_address video read address (registered upstream)
//   vram_data    video read data
//   cpu_req      CPU request level; cpu_we/cpu_addr/cpu_wdata stable while high
//   cpu_rdata    CPU read data, valid while cpu_ack is high
//   cpu_ack      CPU acknowledge
//   ram_addr     RAM address (holds its last value on idle cycles)
//   ram_we       RAM write enable
//   ram_wdata    RAM write data
//   ram_rdata    RAM read data, one cycle after the address
//
// CPU FSM
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_IDLE  | no CPU transaction outstanding
//   S_WAIT  | request seen, waiting for a cycle the video side leaves free
//   S_RDATA | read granted last cycle; capture ram_rdata
//   S_ACK   | cpu_ack high until cpu_req drops

module vram_arbiter #(
    parameter int MAX_WAIT = 8,
    parameter int ADDR_W   = 13
) (
    input  logic              clk_pix,
    input  logic              reset,
    input  logic [ADDR_W-1:0] vram_address,
    output logic [7:0]        vram_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RDATA, S_ACK} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CPU} owner_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t            state_q, state_d;
    owner_t            owner_q;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0] vid_last_q;
    logic              vid_valid_q;
    logic [7:0]        vid_hold_q;
    logic [7:0]        cpu_rdata_q;
    logic              cpu_ack_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [7:0]        ram_wdata_q;

    logic vid_need;
    logic cpu_grant;
    logic vid_grant;
    logic fwd_hit;

    assign vid_need = !vid_valid_q || (vram_address != vid_last_q);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        cpu_grant  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = 8'd0;
                end
            end
            S_WAIT: begin
                if (!cpu_req) begin
                    // request withdrawn before grant: abandon, no RAM access
                    state_d    = S_IDLE;
                    wait_cnt_d = 8'd0;
                end else if (!vid_need || (wait_cnt_q == WAIT_LAST)) begin
                    cpu_grant = 1'b1;
                    state_d   = cpu_we ? S_ACK : S_RDATA;
                end else if (wait_cnt_q != 8'hFF) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_RDATA: state_d = S_ACK;
            S_ACK: begin
                if (!cpu_req) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A forced CPU grant takes the cycle even if the video side needs it.
    assign vid_grant = vid_need && !cpu_grant;

    // A CPU write to the address the video side currently shows must be
    // visible on vram_data without re-reading the RAM.
    assign fwd_hit = cpu_grant && cpu_we && vid_valid_q && (cpu_addr == vid_last_q);

    assign ram_addr  = cpu_grant ? cpu_addr : (vid_grant ? vram_address : ram_addr_q);
    assign ram_we    = cpu_grant && cpu_we && !reset;
    assign ram_wdata = cpu_grant ? cpu_wdata : ram_wdata_q;

    assign vram_data = (owner_q == OWN_VID) ? ram_rdata : vid_hold_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ack   = cpu_ack_q;

    always_ff @(posedge clk_pix) begin
        if (reset) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_NONE;
            wait_cnt_q  <= 8'd0;
            vid_last_q  <= '0;
            vid_valid_q <= 1'b0;
            vid_hold_q  <= 8'd0;
            cpu_rdata_q <= 8'd0;
            cpu_ack_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            cpu_ack_q   <= (state_d == S_ACK);
            ram_addr_q  <= ram_addr;
            ram_wdata_q <= ram_wdata;
            vid_hold_q  <= fwd_hit ? cpu_wdata : vram_data;

            if (vid_grant) begin
                vid_last_q  <= vram_address;
                vid_valid_q <= 1'b1;
                owner_q     <= OWN_VID;
            end else if (cpu_grant) begin
                owner_q <= cpu_we ? OWN_NONE : OWN_CPU;
            end else begin
                owner_q <= OWN_NONE;
            end

            if (state_q == S_RDATA) cpu_rdata_q <= ram_rdata;
        end
    end

endmodule
